alu_req_arbiter: RTL and testbench

- Shares one registered ALU instance between two requesters (n = 0, 1).
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU control and operand inputs, holds them stable for the ALU's fixed latency, captures result and flags, and returns them to the granted requester over a valid/ready response channel.
- Sits between command sources (sequencer, test host) and the ALU datapath.

---
 rtl/alu_req_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one fixed-latency registered ALU between two requesters
module alu_req_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int RES_WIDTH = 16,
    parameter int ALU_LAT   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0_VALID,
    output logic                 REQ0_READY,
    input  logic [WIDTH-1:0]     REQ0_OPA,
    input  logic [WIDTH-1:0]     REQ0_OPB,
    input  logic                 REQ0_CIN,
    input  logic                 REQ0_MODE,
    input  logic [CMD_WIDTH-1:0] REQ0_CMD,
    input  logic [1:0]           REQ0_INP_VALID,
    input  logic                 REQ1_VALID,
    output logic                 REQ1_READY,
    input  logic [WIDTH-1:0]     REQ1_OPA,
    input  logic [WIDTH-1:0]     REQ1_OPB,
    input  logic                 REQ1_CIN,
    input  logic                 REQ1_MODE,
    input  logic [CMD_WIDTH-1:0] REQ1_CMD,
    input  logic [1:0]           REQ1_INP_VALID,
    output logic                 RSP0_VALID,
    input  logic                 RSP0_READY,
    output logic                 RSP1_VALID,
    input  logic                 RSP1_READY,
    output logic [RES_WIDTH-1:0] RSP_RES,
    output logic [5:0]           RSP_FLAGS,
    output logic [WIDTH-1:0]     ALU_OPA,
    output logic [WIDTH-1:0]     ALU_OPB,
    output logic                 ALU_CIN,
    output logic                 ALU_MODE,
    output logic                 ALU_CE,
    output logic [CMD_WIDTH-1:0] ALU_CMD,
    output logic [1:0]           ALU_INP_VALID,
    input  logic [RES_WIDTH-1:0] ALU_RES,
    input  logic                 ALU_COUT,
    input  logic                 ALU_OFLOW,
    input  logic                 ALU_G,
    input  logic                 ALU_E,
    input  logic                 ALU_L,
    input  logic                 ALU_ERR,
    output logic                 BUSY,
    output logic                 GRANT_ID,
    output logic [CNT_WIDTH-1:0] OP_COUNT
);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic                 any;
    logic                 gnt;
    logic                 drive;
    logic                 rsp_rdy;
    logic [WIDTH-1:0]     h_opa;
    logic [WIDTH-1:0]     h_opb;
    logic                 h_cin;
    logic                 h_mode;
    logic [CMD_WIDTH-1:0] h_cmd;
    logic [1:0]           h_iv;
    assign any   = REQ0_VALID | REQ1_VALID;
    // on a tie the requester that did not win last time gets the ALU
    assign gnt   = (REQ0_VALID & REQ1_VALID) ? ~last : REQ1_VALID;
    assign REQ0_READY = (state == IDLE) & any & ~gnt;
    assign REQ1_READY = (state == IDLE) & gnt;
    assign drive = (state == ISSUE) | (state == WAIT);
    assign ALU_CE        = drive;
    assign ALU_OPA       = drive ? h_opa  : '0;
    assign ALU_OPB       = drive ? h_opb  : '0;
    assign ALU_CIN       = drive & h_cin;
    assign ALU_MODE      = drive & h_mode;
    assign ALU_CMD       = drive ? h_cmd  : '0;
    assign ALU_INP_VALID = drive ? h_iv   : '0;
    assign RSP0_VALID = (state == RESP) & ~GRANT_ID;
    assign RSP1_VALID = (state == RESP) & GRANT_ID;
    assign rsp_rdy    = GRANT_ID ? RSP1_READY : RSP0_READY;
    assign BUSY       = state != IDLE;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            GRANT_ID  <= 1'b0;
            OP_COUNT  <= '0;
            RSP_RES   <= '0;
            RSP_FLAGS <= '0;
            h_opa     <= '0;
            h_opb     <= '0;
            h_cin     <= 1'b0;
            h_mode    <= 1'b0;
            h_cmd     <= '0;
            h_iv      <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    h_opa    <= gnt ? REQ1_OPA       : REQ0_OPA;
                    h_opb    <= gnt ? REQ1_OPB       : REQ0_OPB;
                    h_cin    <= gnt ? REQ1_CIN       : REQ0_CIN;
                    h_mode   <= gnt ? REQ1_MODE      : REQ0_MODE;
                    h_cmd    <= gnt ? REQ1_CMD       : REQ0_CMD;
                    h_iv     <= gnt ? REQ1_INP_VALID : REQ0_INP_VALID;
                    GRANT_ID <= gnt;
                    last     <= gnt;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= CW'(ALU_LAT - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    RSP_RES   <= ALU_RES;
                    RSP_FLAGS <= {ALU_ERR, ALU_L, ALU_E, ALU_G, ALU_OFLOW, ALU_COUT};
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (rsp_rdy) begin
                    OP_COUNT <= OP_COUNT + 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed bench with a two-stage ALU stand-in behind the arbiter
module tb_alu_req_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0_VALID = 0, REQ1_VALID = 0;
    logic        REQ0_READY, REQ1_READY;
    logic [7:0]  REQ0_OPA = 0, REQ0_OPB = 0, REQ1_OPA = 0, REQ1_OPB = 0;
    logic        REQ0_CIN = 0, REQ0_MODE = 0, REQ1_CIN = 0, REQ1_MODE = 0;
    logic [3:0]  REQ0_CMD = 0, REQ1_CMD = 0;
    logic [1:0]  REQ0_INP_VALID = 0, REQ1_INP_VALID = 0;
    logic        RSP0_VALID, RSP1_VALID;
    logic        RSP0_READY = 0, RSP1_READY = 0;
    logic [15:0] RSP_RES;
    logic [5:0]  RSP_FLAGS;
    logic [7:0]  ALU_OPA, ALU_OPB;
    logic        ALU_CIN, ALU_MODE, ALU_CE;
    logic [3:0]  ALU_CMD;
    logic [1:0]  ALU_INP_VALID;
    logic [15:0] ALU_RES;
    logic        ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;
    logic        BUSY, GRANT_ID;
    logic [15:0] OP_COUNT;
    int total = 0;
    int bad = 0;

    alu_req_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OPA(REQ0_OPA), .REQ0_OPB(REQ0_OPB),
        .REQ0_CIN(REQ0_CIN), .REQ0_MODE(REQ0_MODE), .REQ0_CMD(REQ0_CMD), .REQ0_INP_VALID(REQ0_INP_VALID),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OPA(REQ1_OPA), .REQ1_OPB(REQ1_OPB),
        .REQ1_CIN(REQ1_CIN), .REQ1_MODE(REQ1_MODE), .REQ1_CMD(REQ1_CMD), .REQ1_INP_VALID(REQ1_INP_VALID),
        .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
        .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS),
        .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN), .ALU_MODE(ALU_MODE), .ALU_CE(ALU_CE),
        .ALU_CMD(ALU_CMD), .ALU_INP_VALID(ALU_INP_VALID), .ALU_RES(ALU_RES),
        .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW), .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR),
        .BUSY(BUSY), .GRANT_ID(GRANT_ID), .OP_COUNT(OP_COUNT)
    );

    always #5 CLK = ~CLK;

    // ALU stand-in: ADD (mode 1, cmd 0), CMP (mode 1, cmd 8), ROL (mode 0, cmd 12); result after two edges
    function automatic logic [21:0] alu_f(input logic [7:0] a, b, input logic cin, mode, input logic [3:0] cmd);
        logic [15:0] r;
        logic [5:0]  f;
        r = '0;
        f = '0;
        if (mode && cmd == 4'd0) begin
            r = {8'd0, a} + {8'd0, b} + {15'd0, cin};
            f[0] = r[8];
        end else if (mode && cmd == 4'd8) begin
            f[4] = a < b;
            f[3] = a == b;
            f[2] = a > b;
        end else if (!mode && cmd == 4'd12 && b[7:4] == 4'd0) begin
            r = {8'd0, (a << b[2:0]) | (a >> (4'd8 - {1'b0, b[2:0]}))};
        end else begin
            f[5] = 1'b1;
        end
        return {f, r};
    endfunction

    logic [21:0] s1, s2;
    always_ff @(posedge CLK) begin
        s1 <= ALU_CE ? alu_f(ALU_OPA, ALU_OPB, ALU_CIN, ALU_MODE, ALU_CMD) : 22'd0;
        s2 <= s1;
    end
    assign ALU_RES = s2[15:0];
    assign {ALU_ERR, ALU_L, ALU_E, ALU_G, ALU_OFLOW, ALU_COUT} = s2[21:16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [7:0] a, b,
                           input logic cin, mode, input logic [3:0] cmd);
        if (n == 0) begin
            REQ0_VALID = v; REQ0_OPA = a; REQ0_OPB = b; REQ0_CIN = cin;
            REQ0_MODE = mode; REQ0_CMD = cmd; REQ0_INP_VALID = 2'b11;
        end else begin
            REQ1_VALID = v; REQ1_OPA = a; REQ1_OPB = b; REQ1_CIN = cin;
            REQ1_MODE = mode; REQ1_CMD = cmd; REQ1_INP_VALID = 2'b11;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // called at a negedge: waits for a grant, optionally drops that VALID, then collects the response
    task automatic next_op(input logic drop, output logic gid, output logic [15:0] res, output logic [5:0] fl);
        int k;
        logic got;
        #1;
        k = 0;
        got = REQ0_READY | REQ1_READY;
        while (!got && k < 30) begin
            @(negedge CLK);
            #1;
            got = REQ0_READY | REQ1_READY;
            k++;
        end
        chk("grant_seen", {31'd0, got}, 1);
        gid = REQ1_READY;
        @(posedge CLK);
        #1;
        if (drop && gid) REQ1_VALID = 1'b0;
        if (drop && !gid) REQ0_VALID = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < 30) begin
            @(negedge CLK);
            got = gid ? RSP1_VALID : RSP0_VALID;
            k++;
        end
        chk("rsp_seen", {31'd0, got}, 1);
        chk("rsp_other_valid", {31'd0, gid ? RSP0_VALID : RSP1_VALID}, 0);
        res = RSP_RES;
        fl = RSP_FLAGS;
        if (gid) RSP1_READY = 1'b1; else RSP0_READY = 1'b1;
        @(negedge CLK);
        RSP0_READY = 1'b0;
        RSP1_READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gid;
        logic [15:0] res;
        logic [5:0]  fl;
        int          k, ce;
        logic        seen;
        // reset state
        @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_ce", {31'd0, ALU_CE}, 0);
        chk("rst_count", {16'd0, OP_COUNT}, 0);
        chk("rst_grant_id", {31'd0, GRANT_ID}, 0);
        chk("rst_rsp_res", {16'd0, RSP_RES}, 0);
        chk("rst_rsp0_valid", {31'd0, RSP0_VALID}, 0);
        RST = 1'b0;
        // single ADD from requester 0
        @(negedge CLK);
        set_req(0, 1, 8'h12, 8'h34, 0, 1, 4'd0);
        #1;
        chk("t1_req0_ready", {31'd0, REQ0_READY}, 1);
        chk("t1_req1_ready", {31'd0, REQ1_READY}, 0);
        @(posedge CLK);
        #1;
        REQ0_VALID = 1'b0;
        k = 0; ce = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge CLK);
            k++;
            if (k == 1) chk("t1_alu_opa", {24'd0, ALU_OPA}, 32'h12);
            if (RSP0_VALID) seen = 1'b1;
            else if (ALU_CE) ce++;
        end
        chk("t1_latency", k, 4);
        chk("t1_ce_cycles", ce, 3);
        chk("t1_res", {16'd0, RSP_RES}, 32'h46);
        chk("t1_flags", {26'd0, RSP_FLAGS}, 0);
        chk("t1_resp_ce", {31'd0, ALU_CE}, 0);
        chk("t1_resp_opa", {24'd0, ALU_OPA}, 0);
        chk("t1_busy", {31'd0, BUSY}, 1);
        RSP0_READY = 1'b1;
        @(negedge CLK);
        RSP0_READY = 1'b0;
        chk("t1_count", {16'd0, OP_COUNT}, 1);
        chk("t1_idle", {31'd0, BUSY}, 0);
        chk("t1_rsp0_drop", {31'd0, RSP0_VALID}, 0);
        // simultaneous compares after reset
        do_reset();
        set_req(0, 1, 8'h05, 8'h09, 0, 1, 4'd8);
        set_req(1, 1, 8'h09, 8'h05, 0, 1, 4'd8);
        next_op(1, gid, res, fl);
        chk("t2_first_gid", {31'd0, gid}, 0);
        chk("t2_first_flags", {26'd0, fl}, 32'h10);
        next_op(1, gid, res, fl);
        chk("t2_second_gid", {31'd0, gid}, 1);
        chk("t2_second_flags", {26'd0, fl}, 32'h04);
        chk("t2_grant_id", {31'd0, GRANT_ID}, 1);
        // fairness with both continuously valid
        do_reset();
        set_req(0, 1, 8'h01, 8'h01, 0, 1, 4'd0);
        set_req(1, 1, 8'h02, 8'h02, 0, 1, 4'd0);
        for (int i = 0; i < 6; i++) begin
            next_op(0, gid, res, fl);
            chk("t3_gid", {31'd0, gid}, {31'd0, i[0]});
            chk("t3_res", {16'd0, res}, i[0] ? 32'h4 : 32'h2);
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        chk("t3_count", {16'd0, OP_COUNT}, 6);
        // response backpressure on requester 0 while requester 1 waits
        @(negedge CLK);
        set_req(0, 1, 8'h80, 8'h80, 0, 1, 4'd0);
        set_req(1, 1, 8'h01, 8'h02, 0, 1, 4'd0);
        #1;
        chk("t4_req0_ready", {31'd0, REQ0_READY}, 1);
        @(posedge CLK);
        #1;
        REQ0_VALID = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge CLK);
            seen = RSP0_VALID;
            k++;
        end
        chk("t4_rsp_seen", {31'd0, seen}, 1);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", {31'd0, RSP0_VALID}, 1);
            chk("t4_hold_res", {16'd0, RSP_RES}, 32'h100);
            chk("t4_hold_flags", {26'd0, RSP_FLAGS}, 32'h01);
            chk("t4_hold_busy", {31'd0, BUSY}, 1);
            chk("t4_req1_blocked", {31'd0, REQ1_READY}, 0);
            @(negedge CLK);
        end
        RSP0_READY = 1'b1;
        @(negedge CLK);
        RSP0_READY = 1'b0;
        #1;
        chk("t4_req1_ready", {31'd0, REQ1_READY}, 1);
        chk("t4_idle", {31'd0, BUSY}, 0);
        next_op(1, gid, res, fl);
        chk("t4_req1_gid", {31'd0, gid}, 1);
        chk("t4_req1_res", {16'd0, res}, 32'h3);
        // reset during WAIT
        @(negedge CLK);
        set_req(1, 1, 8'h05, 8'h05, 0, 1, 4'd0);
        @(posedge CLK);
        #1;
        REQ1_VALID = 1'b0;
        @(negedge CLK);
        chk("t5_issue_gid", {31'd0, GRANT_ID}, 1);
        chk("t5_issue_ce", {31'd0, ALU_CE}, 1);
        @(negedge CLK);
        chk("t5_wait_ce", {31'd0, ALU_CE}, 1);
        RST = 1'b1;
        #1;
        chk("t5_rst_ce", {31'd0, ALU_CE}, 0);
        chk("t5_rst_busy", {31'd0, BUSY}, 0);
        chk("t5_rst_rsp1", {31'd0, RSP1_VALID}, 0);
        chk("t5_rst_rsp0", {31'd0, RSP0_VALID}, 0);
        chk("t5_rst_count", {16'd0, OP_COUNT}, 0);
        chk("t5_rst_gid", {31'd0, GRANT_ID}, 0);
        @(negedge CLK);
        RST = 1'b0;
        set_req(0, 1, 8'h07, 8'h08, 0, 1, 4'd0);
        set_req(1, 1, 8'h05, 8'h05, 0, 1, 4'd0);
        #1;
        chk("t5_req0_ready", {31'd0, REQ0_READY}, 1);
        chk("t5_req1_ready", {31'd0, REQ1_READY}, 0);
        next_op(1, gid, res, fl);
        chk("t5_gid", {31'd0, gid}, 0);
        chk("t5_res", {16'd0, res}, 32'h0f);
        // error flag forwarded from a rotate with out-of-range amount
        set_req(1, 1, 8'h01, 8'h10, 0, 0, 4'd12);
        next_op(1, gid, res, fl);
        chk("t6_gid", {31'd0, gid}, 1);
        chk("t6_flags", {26'd0, fl}, 32'h20);
        chk("t6_res", {16'd0, res}, 0);
        chk("t6_count", {16'd0, OP_COUNT}, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
